// File: rtl/univ_shift_reg_burst.sv
// Universal shift register with eight single-step modes and a start-triggered
// N-step burst shifter reporting busy/done.
module univ_shift_reg_burst #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ena_i,
    input  logic [2:0]       mode_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             s_in_l_i,
    input  logic             s_in_r_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] burst_len_i,
    input  logic             burst_dir_i,
    output logic [WIDTH-1:0] q_o,
    output logic             s_out_msb_o,
    output logic             s_out_lsb_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] q_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH-1:0] shl_d;
    logic [WIDTH-1:0] shr_d;
    logic [WIDTH-1:0] q_burst_d;
    logic [WIDTH-1:0] q_mode_d;

    always_comb begin
        shl_d     = {q_q[WIDTH-2:0], s_in_l_i};
        shr_d     = {s_in_r_i, q_q[WIDTH-1:1]};
        q_burst_d = dir_q ? shr_d : shl_d;
        q_mode_d  = q_q;
        case (mode_i)
            3'b000: q_mode_d = q_q;
            3'b001: q_mode_d = shl_d;
            3'b010: q_mode_d = d_i;
            3'b011: q_mode_d = shr_d;
            3'b100: q_mode_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            3'b101: q_mode_d = {q_q[0], q_q[WIDTH-1:1]};
            3'b110: q_mode_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            3'b111: q_mode_d = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            q_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ena_i) begin
                        // An accepted start takes priority over mode; q holds.
                        if (start_i && (burst_len_i != '0)) begin
                            state_q <= StRun;
                            cnt_q   <= burst_len_i;
                            dir_q   <= burst_dir_i;
                            busy_q  <= 1'b1;
                        end else begin
                            q_q <= q_mode_d;
                        end
                    end
                end
                StRun: begin
                    if (ena_i) begin
                        q_q   <= q_burst_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    // Leaves DONE unconditionally so done is always one cycle.
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q_o         = q_q;
    assign s_out_msb_o = q_q[WIDTH-1];
    assign s_out_lsb_o = q_q[0];
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Randomised and directed bench for univ_shift_reg_burst against an
// arithmetic reference model of the register and its burst sequence.
module tb_univ_shift_reg_burst;

    localparam int W  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          ena;
    logic [2:0]    mode;
    logic [W-1:0]  d;
    logic          s_in_l;
    logic          s_in_r;
    logic          start;
    logic [CW-1:0] burst_len;
    logic          burst_dir;
    logic [W-1:0]  q;
    logic          s_out_msb;
    logic          s_out_lsb;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Reference model: register value, remaining burst steps, latched direction,
    // and a pending one-cycle done flag.
    int unsigned m_q    = 0;
    int          m_left = 0;
    int unsigned m_dir  = 0;
    bit          m_done = 1'b0;

    always #5 clk = ~clk;

    univ_shift_reg_burst #(
        .WIDTH(W),
        .CNT_W(CW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .ena_i       (ena),
        .mode_i      (mode),
        .d_i         (d),
        .s_in_l_i    (s_in_l),
        .s_in_r_i    (s_in_r),
        .start_i     (start),
        .burst_len_i (burst_len),
        .burst_dir_i (burst_dir),
        .q_o         (q),
        .s_out_msb_o (s_out_msb),
        .s_out_lsb_o (s_out_lsb),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic model_reset();
        m_q = 0; m_left = 0; m_dir = 0; m_done = 1'b0;
    endtask

    function automatic int unsigned apply_mode(int unsigned v, int unsigned md);
        case (md)
            1: return (v * 2 + s_in_l) % 256;
            2: return d;
            3: return v / 2 + s_in_r * 128;
            4: return (v * 2) % 256 + v / 128;
            5: return v / 2 + (v % 2) * 128;
            6: return v / 2 + (v / 128) * 128;
            7: return 0;
            default: return v;
        endcase
    endfunction

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (ena) begin
                m_q    = (m_dir != 0) ? apply_mode(m_q, 3) : apply_mode(m_q, 1);
                m_left = m_left - 1;
                if (m_left == 0) m_done = 1'b1;
            end
        end else if (ena) begin
            if (start && burst_len != 0) begin
                m_left = int'(burst_len);
                m_dir  = burst_dir;
            end else begin
                m_q = apply_mode(m_q, mode);
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        ena = 1'b1; mode = 3'd0; d = '0; s_in_l = 1'b0; s_in_r = 1'b0;
        start = 1'b0; burst_len = '0; burst_dir = 1'b0;
    endtask

    task automatic load(input logic [7:0] v);
        mode = 3'd2; d = v; tick(); mode = 3'd0;
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b1;
        #2;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk); reset = 1'b0; model_reset();
        load(8'h3C);
        start = 1'b1; burst_len = 4'd5; tick(); start = 1'b0;
        tick(); tick();
        checks++; if (busy !== 1'b1 || q !== 8'(m_q)) begin
            errors++; $display("FAIL reset_preburst: got busy=%b q=%h want 1 %h", busy, q, 8'(m_q));
        end
        #3 reset = 1'b1;
        #1;
        checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_midburst: got q=%h busy=%b done=%b want 00 0 0", q, busy, done);
        end
        model_reset();
        tick();
        @(negedge clk); reset = 1'b0;
        tick(); tick();
        checks++; if (q !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_release: got q=%h busy=%b done=%b want 00 0 0", q, busy, done);
        end
    endtask

    task automatic test_modes();
        logic [2:0] md_v [6]  = '{3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        logic [7:0] exp_v [6] = '{8'h4B, 8'h52, 8'h4B, 8'hD2, 8'hD2, 8'h00};
        set_idle();
        load(8'hA5);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL mode_load: got %h want a5", q); end
        for (int i = 0; i < 6; i++) begin
            load(8'hA5);
            mode = md_v[i]; s_in_l = 1'b1; s_in_r = 1'b0;
            tick();
            checks++; if (q !== exp_v[i] || q !== 8'(m_q)) begin
                errors++; $display("FAIL mode_%0d: got %h want %h", md_v[i], q, exp_v[i]);
            end
            checks++; if (s_out_msb !== exp_v[i][7] || s_out_lsb !== exp_v[i][0]) begin
                errors++; $display("FAIL mode_%0d_sout: got msb=%b lsb=%b want %b %b",
                                   md_v[i], s_out_msb, s_out_lsb, exp_v[i][7], exp_v[i][0]);
            end
        end
        mode = 3'd0; tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL mode_hold: got %h want 00", q); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_v [3] = '{8'h02, 8'h04, 8'h08};
        set_idle();
        load(8'h81);
        start = 1'b1; burst_len = 4'd3; burst_dir = 1'b0; mode = 3'd1; s_in_l = 1'b0;
        tick();
        start = 1'b0; mode = 3'd0;
        checks++; if (q !== 8'h81 || busy !== 1'b1 || done !== 1'b0) begin
            errors++; $display("FAIL burst_start: got q=%h busy=%b done=%b want 81 1 0", q, busy, done);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (q !== exp_v[i] || busy !== (i < 2) || done !== (i == 2)) begin
                errors++; $display("FAIL burst_step%0d: got q=%h busy=%b done=%b want %h %b %b",
                                   i + 1, q, busy, done, exp_v[i], i < 2, i == 2);
            end
        end
        tick();
        checks++; if (q !== 8'h08 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL burst_after: got q=%h busy=%b done=%b want 08 0 0", q, busy, done);
        end
    endtask

    task automatic test_ignore();
        set_idle();
        load(8'h81);
        start = 1'b1; burst_len = 4'd3; burst_dir = 1'b0; tick();
        start = 1'b0; tick();
        start = 1'b1; burst_len = 4'd7; burst_dir = 1'b1; mode = 3'd2; d = 8'hFF; s_in_r = 1'b1;
        ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (q !== 8'h02 || busy !== 1'b1) begin
                errors++; $display("FAIL ignore_stall%0d: got q=%h busy=%b want 02 1", i, q, busy);
            end
        end
        ena = 1'b1;
        tick();
        checks++; if (q !== 8'h04 || busy !== 1'b1) begin
            errors++; $display("FAIL ignore_step2: got q=%h busy=%b want 04 1", q, busy);
        end
        tick();
        checks++; if (q !== 8'h08 || done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ignore_step3: got q=%h done=%b busy=%b want 08 1 0", q, done, busy);
        end
        tick();
        checks++; if (q !== 8'h08 || done !== 1'b0 || q !== 8'(m_q)) begin
            errors++; $display("FAIL ignore_donehold: got q=%h done=%b want 08 0", q, done);
        end
        set_idle();
    endtask

    task automatic test_zero_len();
        set_idle();
        load(8'h35);
        start = 1'b1; burst_len = 4'd0; mode = 3'd1; s_in_l = 1'b1;
        tick();
        start = 1'b0; mode = 3'd0;
        checks++; if (q !== 8'h6B || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL zero_len: got q=%h busy=%b done=%b want 6b 0 0", q, busy, done);
        end
        tick();
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL zero_len_after: got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_long_burst();
        set_idle();
        mode = 3'd7; tick(); mode = 3'd0;
        start = 1'b1; burst_len = 4'd10; burst_dir = 1'b1; s_in_r = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++; if (q !== 8'(m_q) || busy !== (m_left > 0) || done !== m_done) begin
                errors++; $display("FAIL long_step%0d: got q=%h busy=%b done=%b want %h %b %b",
                                   i, q, busy, done, 8'(m_q), m_left > 0, m_done);
            end
            if (i >= 8) begin
                checks++; if (q !== 8'hFF) begin
                    errors++; $display("FAIL long_full%0d: got %h want ff", i, q);
                end
            end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL long_done: got %b want 1", done); end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ena       = ($urandom_range(0, 7) != 0);
            mode      = 3'($urandom_range(0, 7));
            d         = 8'($urandom);
            s_in_l    = 1'($urandom);
            s_in_r    = 1'($urandom);
            start     = ($urandom_range(0, 5) == 0);
            burst_len = 4'($urandom);
            burst_dir = 1'($urandom);
            tick();
            checks++; if (q !== 8'(m_q) || busy !== (m_left > 0) || done !== m_done ||
                          s_out_msb !== q[7] || s_out_lsb !== q[0]) begin
                errors++; $display("FAIL random_%0d: got q=%h busy=%b done=%b want %h %b %b",
                                   i, q, busy, done, 8'(m_q), m_left > 0, m_done);
            end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_modes();
        test_burst();
        test_ignore();
        test_zero_len();
        test_long_burst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
